turf_trigger_scheduler: RTL
===========================

// Module: turf_trigger_scheduler
// PURPOSE
//  Sequences all trigger requesters (RF L1-derived, soft/ext, PPS1, PPS2) onto the TURF HOLD buffer ring in the CLK33 domain.
//  Round-robin arbitrates pending requests and allocates one of NUM_BUF circular SURF buffers per trigger.
//  Stamps each trigger with {epoch, event count}, enforces post-trigger holdoff, and frees buffers in order on clr_evt.
//  Sits between the TURF register interface and the HOLD/CMD output path of the trigger interface.
// PARAMETERS
//  NUM_SRC    4   number of trigger requesters (bit 0 = RF, 1 = soft/ext, 2 = PPS1, 3 = PPS2)
//  NUM_BUF    4   HOLD buffers per SURF; power of 2, >=2
//  CNT_W      20  event counter width; EPOCH_W + CNT_W = 32
//  EPOCH_W    12  epoch field width
//  HOLDOFF    16  dead cycles after each issue; >=1
// PORTS
//  clk_i         in   1         CLK33; one clock, everything is synchronous to it
//  rst_n_i       in   1         reset, asynchronous, active-low
//  req_i         in   NUM_SRC   per-source trigger request pulse
//  src_en_i      in   NUM_SRC   per-source enable (level)
//  disable_i     in   1         master disable: blocks latching and issue
//  clr_evt_i     in   1         pulse: release the oldest held buffer
//  clr_all_i     in   1         pulse: synchronous clear of all state
//  epoch_i       in   EPOCH_W   event ID epoch
//  evid_reset_i  in   1         pulse: zero the event counter
//  trig_o        out  1         1-cycle trigger issue strobe
//  trig_buf_o    out  log2(NUM_BUF)  buffer allocated to this trigger; valid with trig_o, held afterwards
//  trig_src_o    out  NUM_SRC   one-hot granted source; valid with trig_o, held afterwards
//  evid_o        out  32        {epoch,count} of the issued event; held afterwards
//  next_id_o     out  32        {epoch_i, current count}
//  hold_o        out  NUM_BUF   bit n = buffer n occupied
//  occ_o         out  log2(NUM_BUF)+1  number of occupied buffers
//  drop_cnt_o    out  16        saturating count of coalesced/blocked requests
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; rr pointer 0; wr/rd pointers 0.
//  Pending: pend[i] sets at the edge where req_i[i]&src_en_i[i]&!disable_i.
//   pend[i] clears when source i is granted.
//   A req arriving while pend[i]=1, or blocked by disable_i, increments drop_cnt_o (saturates at 16'hFFFF).
//  Arbitration: round robin over pend, starting at rr pointer. After a grant, the rr pointer moves to granted+1 mod NUM_SRC.
//  FSM states are IDLE, ISSUE, HOLDOFF, FULL.
//   IDLE -> ISSUE when |pend & !disable_i & occ<NUM_BUF.
//   IDLE -> FULL when |pend & !disable_i & occ==NUM_BUF.
//   ISSUE (exactly 1 cycle):
//    - trig_o=1; trig_buf_o=wr_ptr; trig_src_o=grant; evid_o={epoch_i,count}
//    - hold_o[wr_ptr] sets; wr_ptr++ (wraps); count++ (wraps 2^CNT_W-1 -> 0)
//    - then HOLDOFF.
//   HOLDOFF: runs HOLDOFF cycles, then IDLE. Requests still latch during holdoff.
//   FULL: -> ISSUE on the first cycle with occ<NUM_BUF; -> IDLE if disable_i is asserted.
//  Latency: req_i sampled at edge k, FSM idle with a free buffer -> trig_o high in the cycle after edge k+2.
//   Minimum issue spacing is HOLDOFF+1 cycles.
//  clr_evt_i: if occ>0, clears hold_o[rd_ptr] and rd_ptr++ (wraps); if occ==0 it is ignored.
//   Simultaneous with ISSUE: both take effect, occ is unchanged. This also holds when full.
//  evid_reset_i: count <= 0. It wins over the ISSUE increment; the event issued in that cycle keeps its pre-reset ID.
//  clr_all_i: overrides everything.
//   - pend, hold_o, pointers, occ, count, rr pointer and drop_cnt all go to 0; state goes to IDLE; trig_o is 0 that cycle.
//   - evid_o, trig_buf_o and trig_src_o are also zeroed.
//  Reset asserted mid-operation returns all state to the reset values immediately. No partial issue is emitted.
//  occ_o always equals popcount(hold_o).
// STRUCTURE
//  turf_trig_defs.vh (shared include): FSM state encodings, source index localparams (SRC_RF, SRC_SOFT, SRC_PPS1, SRC_PPS2), EVID field widths.
//  Sub-module turf_rr_arbiter: parameterised NUM_SRC round-robin arbiter.
//   Inputs: req, advance. Outputs: one-hot grant, any.
//   Pointer register lives inside it.
//  Top level holds pending, FSM, buffer ring, counters.
// TESTING
//  1. Reset, src_en=4'hF, req_i=4'b0001 for 1 cycle -> trig_o at edge k+2; trig_buf_o=0; trig_src_o=4'b0001; evid_o={epoch_i,20'd0}; next_id_o count=1; hold_o=4'b0001.
//  2. req_i=4'b1111 in one cycle -> four issues spaced 17 cycles apart, in order src 0,1,2,3; then hold_o=4'hF, occ_o=4.
//     A further req -> FULL, no trig_o. Then clr_evt -> hold_o=4'hE, and issue to buffer 0 follows 1-2 cycles later.
//  3. occ=4, clr_evt_i in the same cycle as a FULL->ISSUE transition -> occ stays 4; rd_ptr=1; wr_ptr=1.
//     clr_evt with occ=0 -> no change.
//  4. Preload count=20'hFFFFF, issue -> evid_o count=FFFFF, next count=0.
//     evid_reset_i coincident with an issue at count=5 -> evid_o count=5, next_id count=0.
//  5. req_i[2] twice while pend[2]=1 -> drop_cnt_o=2, single issue. disable_i=1 plus req -> no pend, drop_cnt_o=3.
//  6. clr_all_i during HOLDOFF with occ=2 -> next cycle all outputs 0, state IDLE; a new req issues to buffer 0.
//     rst_n_i low mid-ISSUE -> outputs 0 asynchronously.

Source files
------------

// File: rtl/turf_trigger_scheduler_pkg.sv
// rtl/turf_trigger_scheduler_pkg.sv - shared types and constants for the TURF trigger scheduler
package turf_trigger_scheduler_pkg;

    localparam int EVID_W = 32;
    localparam int DROP_W = 16;

    localparam int SRC_RF   = 0;
    localparam int SRC_SOFT = 1;
    localparam int SRC_PPS1 = 2;
    localparam int SRC_PPS2 = 3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_HOLDOFF = 2'd2,
        S_FULL    = 2'd3
    } sched_state_t;

    function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] a,
                                                 input logic [DROP_W-1:0] b);
        logic [DROP_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[DROP_W] ? {DROP_W{1'b1}} : s[DROP_W-1:0];
    endfunction

endpackage

// File: rtl/turf_rr_arbiter.sv
// rtl/turf_rr_arbiter.sv - round-robin arbiter; pointer moves past each granted requester
module turf_rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant,
    output logic         any
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] gidx;
    logic [PW-1:0] idx;

    assign any = |req;

    // Scan from the farthest offset down so the nearest requester wins.
    always_comb begin
        grant = '0;
        gidx  = '0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = PW'((int'(ptr_q) + i) % N);
            if (req[idx]) begin
                grant       = '0;
                grant[idx]  = 1'b1;
                gidx        = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (clr) begin
            ptr_q <= '0;
        end else if (advance && any) begin
            ptr_q <= (gidx == PW'(N - 1)) ? '0 : gidx + PW'(1);
        end
    end

endmodule

// File: rtl/turf_trigger_scheduler.sv
// rtl/turf_trigger_scheduler.sv - arbitrates trigger sources onto the HOLD buffer ring with event IDs
module turf_trigger_scheduler
    import turf_trigger_scheduler_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int NUM_BUF = 4,
    parameter int CNT_W   = 20,
    parameter int EPOCH_W = 12,
    parameter int HOLDOFF = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic [NUM_SRC-1:0]           req_i,
    input  logic [NUM_SRC-1:0]           src_en_i,
    input  logic                         disable_i,
    input  logic                         clr_evt_i,
    input  logic                         clr_all_i,
    input  logic [EPOCH_W-1:0]           epoch_i,
    input  logic                         evid_reset_i,
    output logic                         trig_o,
    output logic [$clog2(NUM_BUF)-1:0]   trig_buf_o,
    output logic [NUM_SRC-1:0]           trig_src_o,
    output logic [EVID_W-1:0]            evid_o,
    output logic [EVID_W-1:0]            next_id_o,
    output logic [NUM_BUF-1:0]           hold_o,
    output logic [$clog2(NUM_BUF):0]     occ_o,
    output logic [DROP_W-1:0]            drop_cnt_o
);

    localparam int BUF_W = $clog2(NUM_BUF);
    localparam int OCC_W = BUF_W + 1;
    localparam int HO_W  = $clog2(HOLDOFF + 1);
    localparam int ND_W  = $clog2(NUM_SRC + 1);

    sched_state_t       state_q, state_d;
    logic [NUM_SRC-1:0] pend_q, grant, req_ok, req_new, req_drop;
    logic               any_pend, issue, release_buf, is_full, ho_done;
    logic [BUF_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [NUM_BUF-1:0] hold_q, hold_d;
    logic [OCC_W-1:0]   occ_q;
    logic [CNT_W-1:0]   count_q;
    logic [HO_W-1:0]    ho_cnt_q;
    logic [ND_W-1:0]    n_drop;

    turf_rr_arbiter #(.N(NUM_SRC)) u_arb (
        .clk     (clk_i),
        .rst_n   (rst_n_i),
        .clr     (clr_all_i),
        .req     (pend_q),
        .advance (issue),
        .grant   (grant),
        .any     (any_pend)
    );

    assign issue       = (state_q == S_ISSUE);
    assign release_buf = clr_evt_i && (occ_q != '0);
    assign is_full     = (occ_q == OCC_W'(NUM_BUF));
    // HOLDOFF state lasts HOLDOFF-1 cycles; the IDLE cycle that follows completes the dead time.
    assign ho_done     = (ho_cnt_q == HO_W'((HOLDOFF > 1) ? HOLDOFF - 2 : 0));

    assign req_ok   = req_i & src_en_i;
    assign req_drop = req_ok & (pend_q | {NUM_SRC{disable_i}});
    assign req_new  = req_ok & ~pend_q & {NUM_SRC{~disable_i}};

    assign next_id_o  = {epoch_i, count_q};
    assign hold_o     = hold_q;
    assign occ_o      = occ_q;

    always_comb begin
        n_drop = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            n_drop = n_drop + ND_W'(req_drop[i]);
        end
    end

    always_comb begin
        hold_d = hold_q;
        if (release_buf) hold_d[rd_ptr_q] = 1'b0;
        if (issue)       hold_d[wr_ptr_q] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (any_pend && !disable_i) state_d = is_full ? S_FULL : S_ISSUE;
            S_ISSUE:   state_d = (HOLDOFF > 1) ? S_HOLDOFF : S_IDLE;
            S_HOLDOFF: if (ho_done) state_d = S_IDLE;
            S_FULL: begin
                if (disable_i)                    state_d = S_IDLE;
                else if (!is_full || release_buf) state_d = S_ISSUE;
            end
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            pend_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            hold_q     <= '0;
            occ_q      <= '0;
            count_q    <= '0;
            ho_cnt_q   <= '0;
            drop_cnt_o <= '0;
            trig_o     <= 1'b0;
            trig_buf_o <= '0;
            trig_src_o <= '0;
            evid_o     <= '0;
        end else if (clr_all_i) begin
            state_q    <= S_IDLE;
            pend_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            hold_q     <= '0;
            occ_q      <= '0;
            count_q    <= '0;
            ho_cnt_q   <= '0;
            drop_cnt_o <= '0;
            trig_o     <= 1'b0;
            trig_buf_o <= '0;
            trig_src_o <= '0;
            evid_o     <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= (pend_q & ~(issue ? grant : '0)) | req_new;
            hold_q     <= hold_d;
            occ_q      <= occ_q + OCC_W'(issue) - OCC_W'(release_buf);
            ho_cnt_q   <= (state_q == S_HOLDOFF) ? ho_cnt_q + HO_W'(1) : '0;
            drop_cnt_o <= sat_add(drop_cnt_o, DROP_W'(n_drop));
            trig_o     <= issue;
            if (issue) begin
                trig_buf_o <= wr_ptr_q;
                trig_src_o <= grant;
                evid_o     <= {epoch_i, count_q};
                wr_ptr_q   <= wr_ptr_q + BUF_W'(1);
            end
            if (release_buf) rd_ptr_q <= rd_ptr_q + BUF_W'(1);
            // An ID reset wins over the increment; the event issued now keeps its old ID.
            if (evid_reset_i)  count_q <= '0;
            else if (issue)    count_q <= count_q + CNT_W'(1);
        end
    end

endmodule
